alu_share_arbiter: RTL
======================

# alu_share_arbiter

Round-robin arbiter that shares one pipelined ALU (bitwise/add/sub stage) between REQUESTERS hardware requesters. It accepts one operation per cycle via valid/ready, registers the winning opcode and operands into the ALU input, and tracks the owner tag through the ALU latency. It steers the result back as a one-hot response strobe. It sits between per-thread operand-fetch logic and the ALU result register.

## Interface
- REQUESTERS, 4: number of requesters; ≥2.
- OPCODE_WIDTH, 3: ALU opcode width.
- WORD_WIDTH, 36: operand/result width.
- ALU_LATENCY, 1: cycles from alu_op/alu_a/alu_b presented to alu_result valid; ≥1.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  REQUESTERS  per-requester request valid.
- req_ready  out  REQUESTERS  one-hot grant; accept = req_valid[i] & req_ready[i].
- req_op  in  REQUESTERS*OPCODE_WIDTH  packed opcodes; requester i at [i*OPCODE_WIDTH +: OPCODE_WIDTH].
- req_a, req_b  in  REQUESTERS*WORD_WIDTH  packed operands, same packing.
- req_lock  in  REQUESTERS  grant-hold request; used only with ALU_ARB_LOCK_EN.
- alu_op  out  OPCODE_WIDTH  registered opcode to ALU.
- alu_a, alu_b  out  WORD_WIDTH  registered operands to ALU.
- alu_result  in  WORD_WIDTH  ALU registered result.
- rsp_valid  out  REQUESTERS  one-hot response strobe, one cycle per accepted op.
- rsp_data  out  WORD_WIDTH  equals alu_result; meaningful only while rsp_valid≠0.
- busy  out  1  high while any accepted op has not yet produced rsp_valid.

## Operation
- Arbitration is combinational over req_valid. The grant goes to the first valid requester after last_grant, searching upward with wrap from REQUESTERS-1 to 0. At most one req_ready bit is high. req_ready is zero when req_valid is zero. Requesters must not make req_valid depend on req_ready.
- On accept, last_grant updates to the winner. The winner's op, a and b are registered into alu_op/alu_a/alu_b. issue_tag (one-hot) and issue_valid are registered alongside.
- With no accept, issue_valid=0 and alu_op/alu_a/alu_b are driven to 0. The ALU computes XOR of zeros, which is harmless and never reported.
- The tag pipeline is ALU_LATENCY stages deep, shifting issue_tag every cycle. rsp_valid is the last stage, so it is aligned with alu_result. rsp_data = alu_result (pass-through).
- The ALU has no backpressure. Throughput is one op per cycle, and ops from different requesters may interleave in flight. Responses return in issue order.
- busy = issue_valid | OR of all tag pipeline stages.

## Timing
- Reset (async assert; deassert synchronous to clock):
  - last_grant = REQUESTERS-1, so requester 0 wins first.
  - alu_op/alu_a/alu_b = 0.
  - All tags and rsp_valid = 0; busy = 0.
  - req_ready = 0 while reset_n is low.
- Latency: accept at edge t → alu_* valid during cycle t+1 → rsp_valid/rsp_data during cycle t+1+ALU_LATENCY.
- Reset mid-operation: all in-flight ops are dropped and no rsp_valid is emitted for them. The ALU's own register is not reset; its stale result is never flagged.
- Single requester valid continuously: it is granted every cycle (wrap search returns to itself).
- All requesters valid: grants cycle 0,1,2,3,0… one per cycle, starting after last_grant.

## Configuration
- ALU_ARB_LOCK_EN defined:
  - If an accepted requester had req_lock=1, last_grant is not advanced past it. That requester gets absolute priority the next cycle while req_valid & req_lock stay high.
  - The lock releases the first cycle either is low; round-robin then resumes from that requester.
- ALU_ARB_LOCK_EN undefined: req_lock is ignored (port retained, unused); pure round-robin.

## Test plan
- Reset check: reset_n=0 mid-stream with 2 ops in flight → next cycles rsp_valid=0, busy=0, alu_op=0. After release with all valid, first grant = requester 0.
- Single op: requester 2, op=3'b001, A=36'hF0F, B=36'h0FF, ALU_LATENCY=1 → alu_op=001 at t+1; rsp_valid=4'b0100 with rsp_data=36'h00F at t+2; busy high at t+1 and t+2 only.
- Fairness: all four valid for 8 cycles → grants 0,1,2,3,0,1,2,3; each requester receives exactly 2 responses, in issue order.
- Sparse wrap: last_grant=3, only requesters 1 and 3 valid → grant 1, then 3, then 1.
- Back-to-back interleave, ALU_LATENCY=3: requesters 0 and 1 alternate with op=3'b000 (XOR) and distinct operands → each rsp_valid is tagged to the correct requester with its matching XOR value, 4 cycles after accept.
- Lock (ALU_ARB_LOCK_EN): requester 1 holds req_lock=1 and valid for 3 cycles while 0, 2 and 3 are valid → grants 1,1,1, then 2,3,0 after the lock drops. Without the macro, the same stimulus gives a 1,2,3,0… rotation.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bundle for alu_share_arbiter: request handshake, packed operands and
// the one-hot response strobe.
interface alu_share_arbiter_if #(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned WORD_WIDTH   = 36
);
  logic [REQUESTERS-1:0]              req_valid;
  logic [REQUESTERS-1:0]              req_ready;
  logic [REQUESTERS*OPCODE_WIDTH-1:0] req_op;
  logic [REQUESTERS*WORD_WIDTH-1:0]   req_a;
  logic [REQUESTERS*WORD_WIDTH-1:0]   req_b;
  logic [REQUESTERS-1:0]              req_lock;
  logic [REQUESTERS-1:0]              rsp_valid;
  logic [WORD_WIDTH-1:0]              rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b, req_lock,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_lock,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU among REQUESTERS requesters, with an
// owner-tag pipeline steering results back. Optional grant hold: define ALU_ARB_LOCK_EN.
module alu_share_arbiter #(
  parameter int unsigned REQUESTERS   = 4,
  parameter int unsigned OPCODE_WIDTH = 3,
  parameter int unsigned WORD_WIDTH   = 36,
  parameter int unsigned ALU_LATENCY  = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  alu_share_arbiter_if.slave      req,
  output logic [OPCODE_WIDTH-1:0] alu_op,
  output logic [WORD_WIDTH-1:0]   alu_a,
  output logic [WORD_WIDTH-1:0]   alu_b,
  input  logic [WORD_WIDTH-1:0]   alu_result,
  output logic                    busy
);
  localparam int unsigned IdxW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

  logic [IdxW-1:0]       last_grant_q;
  logic [IdxW-1:0]       grant_idx;
  logic [IdxW-1:0]       cand;
  logic                  found;
  logic [REQUESTERS-1:0] grant;
  logic                  issue_valid_q;
  logic [REQUESTERS-1:0] issue_tag_q;
  logic [REQUESTERS-1:0] tag_q [ALU_LATENCY];

  logic [OPCODE_WIDTH-1:0] sel_op;
  logic [WORD_WIDTH-1:0]   sel_a;
  logic [WORD_WIDTH-1:0]   sel_b;

`ifdef ALU_ARB_LOCK_EN
  logic lock_q;
`else
  logic unused_lock;
  assign unused_lock = ^req.req_lock;
`endif

  // Search upward from the requester after last_grant, wrapping, so the last winner
  // is considered last.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant_q;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned k = 1; k <= REQUESTERS; k++) begin
      cand = IdxW'((32'(last_grant_q) + k) % REQUESTERS);
      if (!found && req.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
`ifdef ALU_ARB_LOCK_EN
    if (lock_q && req.req_valid[last_grant_q] && req.req_lock[last_grant_q]) begin
      found     = 1'b1;
      grant_idx = last_grant_q;
    end
`endif
    if (!reset_n) begin
      found = 1'b0;
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign sel_op = req.req_op[grant_idx*OPCODE_WIDTH +: OPCODE_WIDTH];
  assign sel_a  = req.req_a[grant_idx*WORD_WIDTH +: WORD_WIDTH];
  assign sel_b  = req.req_b[grant_idx*WORD_WIDTH +: WORD_WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q  <= IdxW'(REQUESTERS - 1);
      issue_valid_q <= 1'b0;
      issue_tag_q   <= '0;
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      for (int unsigned i = 0; i < ALU_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
`ifdef ALU_ARB_LOCK_EN
      lock_q <= 1'b0;
`endif
    end else begin
      issue_valid_q <= found;
      issue_tag_q   <= grant;
      // Idle cycles feed zeros so the ALU sees a harmless XOR of zeros.
      alu_op <= found ? sel_op : '0;
      alu_a  <= found ? sel_a : '0;
      alu_b  <= found ? sel_b : '0;
      if (found) begin
        last_grant_q <= grant_idx;
      end
      tag_q[0] <= issue_tag_q;
      for (int unsigned i = 1; i < ALU_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
`ifdef ALU_ARB_LOCK_EN
      lock_q <= found && req.req_lock[grant_idx];
`endif
    end
  end

  always_comb begin
    busy = issue_valid_q;
    for (int unsigned i = 0; i < ALU_LATENCY; i++) begin
      busy = busy | (|tag_q[i]);
    end
  end

  assign req.req_ready = grant;
  assign req.rsp_valid = tag_q[ALU_LATENCY-1];
  assign req.rsp_data  = alu_result;
endmodule
